// File: rtl/armleocpu_avl_arbiter.sv
// rtl/armleocpu_avl_arbiter.sv - two-host to one-target Avalon-MM round-robin arbiter
// Optional read-response timeout is enabled by defining ARMLEOCPU_AVL_ARB_TIMEOUT_EN.
module armleocpu_avl_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [67:0] h_address,
  input  logic [1:0]  h_read,
  input  logic [1:0]  h_write,
  input  logic [63:0] h_writedata,
  input  logic [7:0]  h_byteenable,
  output logic [1:0]  h_waitrequest,
  output logic [31:0] h_readdata,
  output logic [1:0]  h_response,
  output logic [1:0]  h_readdatavalid,

  output logic [33:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  m_response,
  input  logic        m_readdatavalid
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RESP
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  logic [1:0]  req;
  logic [1:0]  wr_eff;
  logic        sel_read;
  logic        sel_write;
  logic [33:0] sel_address;
  logic [31:0] sel_writedata;
  logic [3:0]  sel_byteenable;
  logic        timeout;

  // A host asserting both strobes is treated as reading.
  assign req    = h_read | h_write;
  assign wr_eff = h_write & ~h_read;

  assign sel_read       = h_read[grant_q];
  assign sel_write      = wr_eff[grant_q];
  assign sel_address    = grant_q ? h_address[67:34]    : h_address[33:0];
  assign sel_writedata  = grant_q ? h_writedata[63:32]  : h_writedata[31:0];
  assign sel_byteenable = grant_q ? h_byteenable[7:4]   : h_byteenable[3:0];

`ifdef ARMLEOCPU_AVL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == ST_RESP) && !m_readdatavalid &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Held at zero outside RESP, so it is already clear on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_RESP && !m_readdatavalid && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    h_waitrequest   = 2'b11;
    h_readdatavalid = 2'b00;
    h_readdata      = m_readdata;
    h_response      = m_response;
    m_read          = 1'b0;
    m_write         = 1'b0;
    m_address       = '0;
    m_writedata     = '0;
    m_byteenable    = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_CMD;
          case (req)
            2'b01:   grant_d = 1'b0;
            2'b10:   grant_d = 1'b1;
            default: grant_d = ~last_grant_q;
          endcase
        end
      end

      ST_CMD: begin
        m_read                 = sel_read;
        m_write                = sel_write;
        m_address              = sel_address;
        m_writedata            = sel_writedata;
        m_byteenable           = sel_byteenable;
        h_waitrequest[grant_q] = m_waitrequest;
        if (!sel_read && !sel_write) begin
          // Host withdrew before acceptance: nothing was issued, keep priority.
          state_d = ST_IDLE;
        end else if (!m_waitrequest) begin
          if (sel_write) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
          end else if (m_readdatavalid) begin
            h_readdatavalid[grant_q] = 1'b1;
            state_d                  = ST_IDLE;
            last_grant_d             = grant_q;
          end else begin
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        h_readdatavalid[grant_q] = m_readdatavalid | timeout;
        if (timeout) begin
          h_response = 2'b11;
          h_readdata = '0;
        end
        if (m_readdatavalid || timeout) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_armleocpu_avl_arbiter.sv
// tb/tb_armleocpu_avl_arbiter.sv - directed and randomized checks of armleocpu_avl_arbiter
module tb_armleocpu_avl_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [67:0] h_address;
  logic [1:0]  h_read;
  logic [1:0]  h_write;
  logic [63:0] h_writedata;
  logic [7:0]  h_byteenable;
  logic [1:0]  h_waitrequest;
  logic [31:0] h_readdata;
  logic [1:0]  h_response;
  logic [1:0]  h_readdatavalid;
  logic [33:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic [1:0]  m_response;
  logic        m_readdatavalid;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  armleocpu_avl_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .h_address       (h_address),
    .h_read          (h_read),
    .h_write         (h_write),
    .h_writedata     (h_writedata),
    .h_byteenable    (h_byteenable),
    .h_waitrequest   (h_waitrequest),
    .h_readdata      (h_readdata),
    .h_response      (h_response),
    .h_readdatavalid (h_readdatavalid),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_response      (m_response),
    .m_readdatavalid (m_readdatavalid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    h_address       = '0;
    h_read          = '0;
    h_write         = '0;
    h_writedata     = '0;
    h_byteenable    = '0;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_response      = '0;
    m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Randomized-phase reference model: per-host transaction, target memory, pending read.
  bit          hb[2];
  bit          hph[2];
  bit          hr[2];
  logic [33:0] ha[2];
  logic [31:0] hwd[2];
  logic [3:0]  hbe[2];
  logic [31:0] hexp[2];
  int          wcnt[2];
  logic [31:0] mem[8];
  bit          tp;
  int          tlat;
  logic [31:0] tdata;
  logic [1:0]  tresp;
  int          o, acc, nlow, k, idx, n;
  bit          pend;

  initial begin
    rst_n = 1'b0;
    quiet();

    // Reset state
    do_reset();
    #1;
    check("rst_wait", h_waitrequest, 2'b11);
    check("rst_mrw", {m_read, m_write}, 2'b00);
    check("rst_rdv", h_readdatavalid, 2'b00);
    check("rst_maddr", m_address, 34'h0);

    // Host 0 read, response three cycles after accept
    h_read = 2'b01;
    h_address[33:0] = 34'h0_0000_1000;
    #1;
    check("d1_idle_wait", h_waitrequest, 2'b11);
    check("d1_idle_mread", m_read, 1'b0);
    step(); #1;
    check("d1_cmd_mread", m_read, 1'b1);
    check("d1_cmd_addr", m_address, 34'h0_0000_1000);
    check("d1_cmd_wait", h_waitrequest, 2'b10);
    step(); h_read = 2'b00; #1;
    check("d1_resp1_wait", h_waitrequest, 2'b11);
    check("d1_resp1_rdv", h_readdatavalid, 2'b00);
    check("d1_resp1_mread", m_read, 1'b0);
    step(); #1;
    check("d1_resp2_rdv", h_readdatavalid, 2'b00);
    step();
    m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF; m_response = 2'b00; #1;
    check("d1_rdv", h_readdatavalid, 2'b01);
    check("d1_rdata", h_readdata, 32'hDEADBEEF);
    check("d1_resp", h_response, 2'b00);
    check("d1_resp3_wait", h_waitrequest, 2'b11);
    step(); #1;
    check("d1_stale_idle", h_readdatavalid, 2'b00);

    // Both hosts reading continuously from reset alternate 0,1,0,1
    do_reset();
    h_read = 2'b11;
    h_address[33:0]  = 34'h0_0000_0100;
    h_address[67:34] = 34'h0_0000_0200;
    pend = 1'b0;
    n = 0;
    for (int c = 0; c < 14 && n < 4; c++) begin
      m_readdatavalid = pend;
      m_readdata = 32'hA000_0000 + 32'(n);
      #1;
      if (pend) begin
        check("d2_rdv", h_readdatavalid, (n % 2 == 1) ? 2'b10 : 2'b01);
        check("d2_rdata", h_readdata, 32'hA000_0000 + 32'(n));
        pend = 1'b0;
        n++;
      end else begin
        check("d2_rdv_quiet", h_readdatavalid, 2'b00);
      end
      if (m_read && !m_waitrequest) begin
        check("d2_order", m_address, (n % 2 == 1) ? 34'h0_0000_0200 : 34'h0_0000_0100);
        check("d2_wait", h_waitrequest, (n % 2 == 1) ? 2'b01 : 2'b10);
        pend = 1'b1;
      end
      step();
    end
    check("d2_count", n, 4);

    // Host 1 write held through two waitrequest cycles
    do_reset();
    h_write = 2'b10;
    h_address[67:34]  = 34'h2_0000_0040;
    h_writedata[63:32] = 32'h12345678;
    h_byteenable[7:4] = 4'b0011;
    m_waitrequest = 1'b1;
    #1;
    check("d3_idle_mwrite", m_write, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      check("d3_hold_mwrite", m_write, 1'b1);
      check("d3_hold_data", {m_address, m_writedata, m_byteenable},
            {34'h2_0000_0040, 32'h12345678, 4'b0011});
      check("d3_hold_wait", h_waitrequest, 2'b11);
    end
    step(); m_waitrequest = 1'b0; #1;
    check("d3_acc_mwrite", m_write, 1'b1);
    check("d3_acc_data", m_writedata, 32'h12345678);
    check("d3_acc_wait", h_waitrequest, 2'b01);
    step(); #1;
    check("d3_idle_after", {m_write, h_waitrequest}, 3'b011);
    check("d3_rdv", h_readdatavalid, 2'b00);
    step(); h_write = 2'b00; #1;
    check("d3_abort", {m_read, m_write}, 2'b00);
    step();

    // Zero-latency target on a host 0 read
    do_reset();
    h_read = 2'b01;
    h_address[33:0] = 34'h0_0000_3000;
    #1;
    step();
    m_readdatavalid = 1'b1; m_response = 2'b10; m_readdata = 32'hCAFE0001; #1;
    check("d4_mread", m_read, 1'b1);
    check("d4_rdv", h_readdatavalid, 2'b01);
    check("d4_resp", h_response, 2'b10);
    check("d4_rdata", h_readdata, 32'hCAFE0001);
    step(); m_readdatavalid = 1'b0; #1;
    check("d4_idle", {m_read, h_waitrequest}, 3'b011);
    step(); #1;
    check("d4_cmd_again", m_read, 1'b1);
    m_readdatavalid = 1'b1;
    step();
    quiet();

    // Reset while a read is outstanding drops the late response
    do_reset();
    h_read = 2'b01;
    h_address[33:0] = 34'h0_0000_4000;
    #1;
    step(); #1;
    check("d5_mread", m_read, 1'b1);
    step(); h_read = 2'b00; rst_n = 1'b0; #1;
    step();
    rst_n = 1'b1;
    h_read = 2'b10;
    h_address[67:34] = 34'h0_0000_5000;
    m_readdatavalid = 1'b1; m_readdata = 32'hBAD0BAD0; #1;
    check("d5_stale", h_readdatavalid, 2'b00);
    step(); m_readdatavalid = 1'b0; #1;
    check("d5_h1_cmd", {m_read, m_address}, {1'b1, 34'h0_0000_5000});
    check("d5_h1_wait", h_waitrequest, 2'b01);
    step(); h_read = 2'b00; #1;
    check("d5_h1_resp", h_readdatavalid, 2'b00);
    step(); m_readdatavalid = 1'b1; m_readdata = 32'h5555AAAA; #1;
    check("d5_h1_rdv", h_readdatavalid, 2'b10);
    check("d5_h1_rdata", h_readdata, 32'h5555AAAA);
    step();
    quiet();

`ifdef ARMLEOCPU_AVL_ARB_TIMEOUT_EN
    // Silent target: synthetic DECODEERROR in the fifth RESP cycle
    do_reset();
    h_read = 2'b01;
    h_address[33:0] = 34'h0_0000_6000;
    m_readdata = 32'hFFFF_FFFF;
    m_response = 2'b00;
    #1;
    step(); #1;
    step(); h_read = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("to_wait", h_readdatavalid, 2'b00);
      step();
    end
    #1;
    check("to_rdv", h_readdatavalid, 2'b01);
    check("to_resp", h_response, 2'b11);
    check("to_rdata", h_readdata, 32'h0);
    step(); m_readdatavalid = 1'b1; #1;
    check("to_late", h_readdatavalid, 2'b00);
    step();
    quiet();
`endif

    // Randomized traffic from both hosts against a memory-backed target
    do_reset();
    for (int j = 0; j < 2; j++) begin
      hb[j] = 1'b0; hph[j] = 1'b0; wcnt[j] = 0; hexp[j] = '0;
    end
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    tp = 1'b0;
    tlat = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      for (int j = 0; j < 2; j++) begin
        if (cyc < 1500 && !hb[j] && $urandom_range(0, 2) == 0) begin
          hb[j]  = 1'b1;
          hph[j] = 1'b0;
          hr[j]  = 1'($urandom_range(0, 1));
          ha[j]  = 34'($urandom_range(0, 7) * 4);
          hwd[j] = $urandom;
          hbe[j] = 4'($urandom_range(1, 15));
        end
        h_read[j]  = hb[j] && !hph[j] && hr[j];
        h_write[j] = hb[j] && !hph[j] && !hr[j];
        h_address[34*j +: 34]  = ha[j];
        h_writedata[32*j +: 32] = hwd[j];
        h_byteenable[4*j +: 4]  = hbe[j];
      end
      m_waitrequest = ($urandom_range(0, 2) == 0);
      if (tp && tlat == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata = tdata;
        m_response = tresp;
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata = $urandom;
        m_response = 2'($urandom);
      end
      #1;

      o = 0;
      for (int j = 0; j < 2; j++) if (hb[j] && hph[j]) o = j;
      if (tp && tlat == 0) begin
        check("rnd_rdv", h_readdatavalid, (o == 1) ? 2'b10 : 2'b01);
        check("rnd_rdata", h_readdata, hexp[o]);
        check("rnd_rresp", h_response, tresp);
      end else begin
        check("rnd_rdv_none", h_readdatavalid, 2'b00);
      end

      nlow = 0;
      acc = -1;
      for (int j = 0; j < 2; j++) begin
        if (!h_waitrequest[j]) begin
          nlow++;
          acc = j;
        end
      end
      check("rnd_single_acc", nlow <= 1, 1'b1);
      if ((m_read || m_write) && !m_waitrequest) check("rnd_issue_acc", nlow, 1);
      if (acc >= 0) begin
        check("rnd_acc_req", hb[acc] && !hph[acc], 1'b1);
        check("rnd_acc_cmd", {m_read, m_write, m_address}, {hr[acc], !hr[acc], ha[acc]});
        if (!hr[acc]) check("rnd_acc_wdata", {m_writedata, m_byteenable}, {hwd[acc], hbe[acc]});
        check("rnd_acc_mwait", m_waitrequest, 1'b0);
      end

      if (tp && tlat == 0) begin
        tp = 1'b0;
        hb[o] = 1'b0;
        hph[o] = 1'b0;
      end else if (tp) begin
        tlat--;
      end
      if (acc >= 0 && hb[acc] && !hph[acc]) begin
        k = 1 - acc;
        if (hb[k] && !hph[k]) begin
          wcnt[k]++;
          check("rnd_fair", wcnt[k] <= 1, 1'b1);
        end
        wcnt[acc] = 0;
        idx = int'(ha[acc][4:2]);
        if (hr[acc]) begin
          hph[acc]  = 1'b1;
          hexp[acc] = mem[idx];
          tp    = 1'b1;
          tlat  = $urandom_range(0, 3);
          tdata = mem[idx];
          tresp = 2'($urandom);
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (hbe[acc][b]) mem[idx][8*b +: 8] = hwd[acc][8*b +: 8];
          end
          hb[acc] = 1'b0;
        end
      end
      step();
    end
    check("rnd_drain", {hb[0], hb[1]}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/armleocpu_avl_arbiter.md
Name: armleocpu_avl_arbiter

Overview:
Two-host to one-target Avalon-MM arbiter that shares the core's single memory port between the page-table walker and the cache. Host 0 is the PTW and host 1 is the cache by convention; the logic is symmetric. Only one transaction is in flight at a time, with burstcount fixed at 1. Grant is round-robin and is held from command issue until completion (write accepted, or read data returned).

Parameters:
TIMEOUT_CYCLES, 255, number of cycles in RESP without m_readdatavalid before a synthetic error is returned (used only with the optional feature).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
h_address  in  2*34  host addresses; host i occupies bits [34*i+33:34*i]
h_read  in  2  per-host read request
h_write  in  2  per-host write request
h_writedata  in  2*32  per-host write data
h_byteenable  in  2*4  per-host byte enables
h_waitrequest  out  2  per-host stall
h_readdata  out  32  read data, shared by both hosts
h_response  out  2  response code, shared by both hosts
h_readdatavalid  out  2  per-host read-data strobe
m_address  out  34  target address
m_read  out  1  target read
m_write  out  1  target write
m_writedata  out  32  target write data
m_byteenable  out  4  target byte enables
m_waitrequest  in  1  target stall
m_readdata  in  32  target read data
m_response  in  2  target response
m_readdatavalid  in  1  target read-data strobe

Behaviour:
- Registered state: state in {IDLE, CMD, RESP}, grant (1 bit), last_grant (1 bit).
- Reset (rst_n low at a clk edge): state=IDLE, grant=0, last_grant=1 (so host 0 wins the first tie). All combinational outputs then follow the IDLE rules below.
- A host is requesting when req[i] = h_read[i] | h_write[i]. If both are high, read wins: the effective write is h_write & ~h_read.
- IDLE:
  - Outputs: h_waitrequest=2'b11, h_readdatavalid=0, m_read=0, m_write=0, m_address/m_writedata/m_byteenable=0.
  - Only req[0]: grant<=0. Only req[1]: grant<=1. Both: grant<=~last_grant.
  - Any request: state<=CMD. No request: stay in IDLE.
  - Arbitration costs exactly 1 cycle; the earliest m_read/m_write is the cycle after the request is first seen.
- CMD:
  - m_* is driven from host[grant].
  - h_waitrequest[grant]=m_waitrequest; h_waitrequest[~grant]=1.
  - m_waitrequest high: stay in CMD.
  - m_waitrequest low with a write: state<=IDLE, last_grant<=grant.
  - m_waitrequest low with a read: state<=RESP. Exception: if m_readdatavalid is also high that cycle (zero-latency target), forward it and go directly to IDLE, last_grant<=grant.
  - Granted host drops both read and write while in CMD: abort, state<=IDLE, nothing issued, last_grant unchanged.
- RESP:
  - m_read=0, m_write=0; h_waitrequest=2'b11.
  - h_readdata=m_readdata, h_response=m_response, h_readdatavalid[grant]=m_readdatavalid, h_readdatavalid[~grant]=0.
  - On m_readdatavalid: state<=IDLE, last_grant<=grant.
- m_readdatavalid seen in IDLE, or in CMD without an accepted read, is ignored and never forwarded. A stale response after reset is therefore dropped.
- h_readdata/h_response equal m_readdata/m_response in every state; hosts must qualify them with h_readdatavalid.
- Fairness: a host requesting continuously against a busy peer is served within 2 transactions.

Optional Feature:
ARMLEOCPU_AVL_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RESP and increments each RESP cycle without m_readdatavalid.
  - When it reaches TIMEOUT_CYCLES: h_readdatavalid[grant]=1 for one cycle with h_response=2'b11 (DECODEERROR) and h_readdata=0; state<=IDLE, last_grant<=grant.
  - A later target response is ignored per the IDLE rule.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: RESP waits indefinitely; no counter is generated.

Test Plan:
- Host 0 reads 0x0_0000_1000, target returns 0xDEADBEEF with response 0 three cycles after accept -> h_readdatavalid=2'b01 with h_readdata=0xDEADBEEF; h_waitrequest[1] high throughout.
- Both hosts read from reset, back to back -> order host0, host1, host0, host1; h_readdatavalid never high for the non-granted host.
- Host 1 writes 0x12345678 with byteenable 4'b0011, m_waitrequest high for 2 cycles -> m_write held 3 cycles with stable data; state returns to IDLE the cycle after accept; no readdatavalid.
- Zero-latency target (m_readdatavalid with accept) on a host 0 read, m_response=2'b10 -> same-cycle h_readdatavalid[0]=1, h_response=2'b10, back in IDLE next cycle.
- rst_n low during RESP, then target returns data -> h_readdatavalid stays 0; next host 1 request proceeds normally.
- With timeout enabled and TIMEOUT_CYCLES=4, target never responds -> h_readdatavalid[grant]=1 with response 2'b11 in the 5th RESP cycle; a later m_readdatavalid is ignored.
